cluster_encoder: RTL and testbench



---
 rtl/cluster_pkg.sv | 34 +++
 rtl/priority_encoder_64.sv | 28 ++
 rtl/cluster_encoder.sv | 201 ++++++++++++++++++++
 tb/tb_cluster_encoder.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/cluster_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cluster_pkg
//  Description : Shared constants and types for the cluster encoder: segment
//                geometry, address/slot widths and the collector state type.
//  Revision    : 1.0  initial release
// ============================================================================
package cluster_pkg;

   localparam int MXSEGS     = 12;
   localparam int SEGSIZE    = 64;
   localparam int MXADRB     = 10;
   localparam int MXCLUSTERS = 8;

   localparam int VPFW       = MXSEGS * SEGSIZE;   // 768 strips
   localparam int SEGIDXW    = 4;                  // segment index width
   localparam int OFFW       = 6;                  // bit offset inside a segment
   localparam int CNTW       = 4;                  // slot count 0..MXCLUSTERS
   localparam int SLOTIDXW   = 3;                  // slot index 0..MXCLUSTERS-1

   localparam logic [MXADRB-1:0] INVALID_ADR    = {MXADRB{1'b1}};
   localparam logic [CNTW-1:0]   MXCLUSTERS_CNT = CNTW'(MXCLUSTERS);

   // One cluster slot holds one strip address
   typedef logic [MXADRB-1:0] slot_t;

   // Collector state: addresses are ignored until the first frame boundary
   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_COLLECT = 1'b1
   } coll_state_e;

endpackage
`default_nettype wire

// File: rtl/priority_encoder_64.sv
`default_nettype none
// ============================================================================
//  Module      : priority_encoder_64
//  Description : Combinational LSB-first encoder for one 64-bit segment.
//                active = any bit set, off = position of the lowest set bit.
//  Revision    : 1.0  initial release
// ============================================================================
module priority_encoder_64
   import cluster_pkg::*;
(
   input  logic [SEGSIZE-1:0] seg,
   output logic               active,
   output logic [OFFW-1:0]    off
);

   // Scan from the top down so the lowest set bit is the last one to win
   always_comb begin
      active = |seg;
      off    = '0;
      for (int i = SEGSIZE - 1; i >= 0; i--) begin
         if (seg[i]) begin
            off = OFFW'(i);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/cluster_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : cluster_encoder
//  Description : 3-stage pipelined priority encoder over the 768-bit VPF
//                vector (one address per cycle) plus a per-frame collector
//                that gathers up to MXCLUSTERS addresses for the packer.
//  Revision    : 1.0  initial release
// ============================================================================
module cluster_encoder
   import cluster_pkg::*;
(
   input  logic                         clock,
   input  logic                         global_reset_n,
   input  logic                         frame_start,
   input  logic [VPFW-1:0]              vpfs_in,
   output logic [MXADRB-1:0]            adr_out,
   output logic                         adr_valid,
   output logic [MXCLUSTERS*MXADRB-1:0] clusters_out,
   output logic [CNTW-1:0]              cluster_cnt,
   output logic                         overflow,
   output logic                         frame_valid
);

   // ---------------- Stage 1: per-segment encode ----------------
   logic [MXSEGS-1:0] seg_act_d;
   logic [MXSEGS-1:0] seg_act_q;
   logic [OFFW-1:0]   seg_off_d [MXSEGS];
   logic [OFFW-1:0]   seg_off_q [MXSEGS];

   generate
      for (genvar g = 0; g < MXSEGS; g++) begin : g_seg
         priority_encoder_64 u_enc (
            .seg    (vpfs_in[g*SEGSIZE +: SEGSIZE]),
            .active (seg_act_d[g]),
            .off    (seg_off_d[g])
         );
      end
   endgenerate

   // Register the per-segment active flags and offsets
   always_ff @(posedge clock or negedge global_reset_n) begin
      if (!global_reset_n) begin
         seg_act_q <= '0;
         for (int i = 0; i < MXSEGS; i++) begin
            seg_off_q[i] <= '0;
         end
      end else begin
         seg_act_q <= seg_act_d;
         for (int i = 0; i < MXSEGS; i++) begin
            seg_off_q[i] <= seg_off_d[i];
         end
      end
   end

   // ---------------- Stage 2: lowest active segment ----------------
   logic [SEGIDXW-1:0] segidx_d;
   logic [OFFW-1:0]    off_d;
   logic               any_d;
   logic [SEGIDXW-1:0] segidx_q;
   logic [OFFW-1:0]    off_q;
   logic               any_q;

   // 12-input priority mux: the lowest-index active segment wins
   always_comb begin
      segidx_d = '0;
      off_d    = '0;
      any_d    = |seg_act_q;
      for (int i = MXSEGS - 1; i >= 0; i--) begin
         if (seg_act_q[i]) begin
            segidx_d = SEGIDXW'(i);
            off_d    = seg_off_q[i];
         end
      end
   end

   // Register the selected segment, its offset and the any-hit flag
   always_ff @(posedge clock or negedge global_reset_n) begin
      if (!global_reset_n) begin
         segidx_q <= '0;
         off_q    <= '0;
         any_q    <= 1'b0;
      end else begin
         segidx_q <= segidx_d;
         off_q    <= off_d;
         any_q    <= any_d;
      end
   end

   // ---------------- Stage 3: address output ----------------
   logic [MXADRB-1:0] adr_q;
   logic              adr_valid_q;

   // segidx*64 + off is a plain concatenation; hold the last address when idle
   always_ff @(posedge clock or negedge global_reset_n) begin
      if (!global_reset_n) begin
         adr_q       <= '0;
         adr_valid_q <= 1'b0;
      end else begin
         adr_valid_q <= any_q;
         if (any_q) begin
            adr_q <= {segidx_q, off_q};
         end
      end
   end

   // ---------------- frame_start alignment ----------------
   logic [2:0] start_sr_q;
   logic       start_d3;

   // Delay frame_start by the pipeline depth so it lines up with adr_out
   always_ff @(posedge clock or negedge global_reset_n) begin
      if (!global_reset_n) begin
         start_sr_q <= '0;
      end else begin
         start_sr_q <= {start_sr_q[1:0], frame_start};
      end
   end

   assign start_d3 = start_sr_q[2];

   // ---------------- Collector ----------------
   coll_state_e                  state_q;
   slot_t                        slots_q [MXCLUSTERS];
   logic [CNTW-1:0]              cnt_q;
   logic                         ovf_q;
   logic [MXCLUSTERS*MXADRB-1:0] clusters_q;
   logic [CNTW-1:0]              cluster_cnt_q;
   logic                         overflow_q;
   logic                         frame_valid_q;

   // Frame collector FSM; an address coinciding with start_d3 opens the new
   // frame (slot 0) and is not part of the frame being closed
   always_ff @(posedge clock or negedge global_reset_n) begin
      if (!global_reset_n) begin
         state_q       <= ST_IDLE;
         for (int i = 0; i < MXCLUSTERS; i++) begin
            slots_q[i] <= INVALID_ADR;
         end
         cnt_q         <= '0;
         ovf_q         <= 1'b0;
         clusters_q    <= '1;
         cluster_cnt_q <= '0;
         overflow_q    <= 1'b0;
         frame_valid_q <= 1'b0;
      end else begin
         frame_valid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start_d3) begin
                  state_q <= ST_COLLECT;
                  for (int i = 0; i < MXCLUSTERS; i++) begin
                     slots_q[i] <= INVALID_ADR;
                  end
                  ovf_q <= 1'b0;
                  if (adr_valid_q) begin
                     slots_q[0] <= adr_q;
                     cnt_q      <= CNTW'(1);
                  end else begin
                     cnt_q      <= '0;
                  end
               end
            end
            ST_COLLECT: begin
               if (start_d3) begin
                  for (int i = 0; i < MXCLUSTERS; i++) begin
                     clusters_q[i*MXADRB +: MXADRB] <= slots_q[i];
                     slots_q[i] <= INVALID_ADR;
                  end
                  cluster_cnt_q <= cnt_q;
                  overflow_q    <= ovf_q;
                  frame_valid_q <= 1'b1;
                  ovf_q         <= 1'b0;
                  if (adr_valid_q) begin
                     slots_q[0] <= adr_q;
                     cnt_q      <= CNTW'(1);
                  end else begin
                     cnt_q      <= '0;
                  end
               end else if (adr_valid_q) begin
                  if (cnt_q < MXCLUSTERS_CNT) begin
                     slots_q[cnt_q[SLOTIDXW-1:0]] <= adr_q;
                     cnt_q <= cnt_q + CNTW'(1);
                  end else begin
                     ovf_q <= 1'b1;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign adr_out      = adr_q;
   assign adr_valid    = adr_valid_q;
   assign clusters_out = clusters_q;
   assign cluster_cnt  = cluster_cnt_q;
   assign overflow     = overflow_q;
   assign frame_valid  = frame_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_cluster_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cluster_encoder
//  Description : Self-checking bench for cluster_encoder: a per-cycle table
//                of inputs and expected outputs, plus hand-written reset
//                sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cluster_encoder;
   import cluster_pkg::*;

   localparam int NROWS = 40;
   localparam int CLW   = MXCLUSTERS * MXADRB;

   logic                clock = 1'b0;
   logic                global_reset_n;
   logic                frame_start;
   logic [VPFW-1:0]     vpfs_in;
   logic [MXADRB-1:0]   adr_out;
   logic                adr_valid;
   logic [CLW-1:0]      clusters_out;
   logic [CNTW-1:0]     cluster_cnt;
   logic                overflow;
   logic                frame_valid;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic              fs;
      logic [VPFW-1:0]   vec;
      logic              ev;
      logic [MXADRB-1:0] eadr;
      logic              efv;
      logic [CNTW-1:0]   ecnt;
      logic              eovf;
      logic [CLW-1:0]    eclus;
   } row_t;

   row_t tbl [NROWS];

   cluster_encoder dut (
      .clock          (clock),
      .global_reset_n (global_reset_n),
      .frame_start    (frame_start),
      .vpfs_in        (vpfs_in),
      .adr_out        (adr_out),
      .adr_valid      (adr_valid),
      .clusters_out   (clusters_out),
      .cluster_cnt    (cluster_cnt),
      .overflow       (overflow),
      .frame_valid    (frame_valid)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_reset(input string tag);
      chk({tag, " adr_out"},      128'(adr_out),      128'(0));
      chk({tag, " adr_valid"},    128'(adr_valid),    128'(0));
      chk({tag, " clusters_out"}, 128'(clusters_out), 128'({CLW{1'b1}}));
      chk({tag, " cluster_cnt"},  128'(cluster_cnt),  128'(0));
      chk({tag, " overflow"},     128'(overflow),     128'(0));
      chk({tag, " frame_valid"},  128'(frame_valid),  128'(0));
   endtask

   function automatic logic [VPFW-1:0] range_vec(input int lo, input int hi);
      logic [VPFW-1:0] v;
      v = '0;
      for (int b = lo; b <= hi; b++) v[b] = 1'b1;
      return v;
   endfunction

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [VPFW-1:0]   v;
      logic [CLW-1:0]    c;
      logic [MXADRB-1:0] hold;

      // ---------------- build the vector table ----------------
      for (int i = 0; i < NROWS; i++) begin
         tbl[i].fs    = 1'b0;
         tbl[i].vec   = '0;
         tbl[i].ev    = 1'b0;
         tbl[i].eadr  = '0;
         tbl[i].efv   = 1'b0;
         tbl[i].ecnt  = '0;
         tbl[i].eovf  = 1'b0;
         tbl[i].eclus = '1;
      end
      // first start after reset only opens collection
      tbl[0].fs = 1'b1;
      // stream 3, 70, 767 truncated one per cycle
      v = '0; v[3] = 1'b1; v[70] = 1'b1; v[767] = 1'b1;
      tbl[5].fs = 1'b1; tbl[5].vec = v;
      v[3] = 1'b0;  tbl[6].vec = v;
      v[70] = 1'b0; tbl[7].vec = v;
      tbl[8].ev  = 1'b1; tbl[8].eadr  = 10'd3;
      tbl[9].ev  = 1'b1; tbl[9].eadr  = 10'd70;
      tbl[10].ev = 1'b1; tbl[10].eadr = 10'd767;
      // empty frame closed by start_d3 at 8 (addr 3 opens the new frame)
      tbl[9].efv = 1'b1;
      // frame close with 3 hits
      tbl[13].fs = 1'b1;
      c = '1; c[0 +: 10] = 10'd3; c[10 +: 10] = 10'd70; c[20 +: 10] = 10'd767;
      tbl[17].efv = 1'b1; tbl[17].ecnt = 4'd3; tbl[17].eclus = c;
      // overflow: bits 0..9 truncated over 10 cycles
      for (int k = 0; k < 10; k++) begin
         tbl[14+k].vec  = range_vec(k, 9);
         tbl[17+k].ev   = 1'b1;
         tbl[17+k].eadr = MXADRB'(k);
      end
      tbl[25].fs = 1'b1;
      c = '1;
      for (int k = 0; k < 8; k++) c[k*10 +: 10] = MXADRB'(k);
      tbl[29].efv = 1'b1; tbl[29].ecnt = 4'd8; tbl[29].eovf = 1'b1; tbl[29].eclus = c;
      // back-to-back empty frames, hit at bit 64 on the start_d3 cycle
      tbl[26].fs = 1'b1;
      v = '0; v[64] = 1'b1;
      tbl[27].fs = 1'b1; tbl[27].vec = v;
      tbl[30].ev = 1'b1; tbl[30].eadr = 10'd64;
      tbl[30].efv = 1'b1;
      tbl[31].efv = 1'b1;
      tbl[32].fs = 1'b1;
      c = '1; c[0 +: 10] = 10'd64;
      tbl[36].efv = 1'b1; tbl[36].ecnt = 4'd1; tbl[36].eclus = c;

      // ---------------- reset with random inputs ----------------
      global_reset_n = 1'b0;
      frame_start    = 1'b0;
      vpfs_in        = '0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clock); #1;
         frame_start = 1'($urandom_range(0, 1));
         for (int w = 0; w < VPFW / 32; w++) vpfs_in[w*32 +: 32] = $urandom();
         @(negedge clock);
         check_reset($sformatf("rst%0d", k));
      end
      frame_start    = 1'b0;
      vpfs_in        = '0;
      global_reset_n = 1'b1;

      // ---------------- table-driven run ----------------
      hold = '0;
      for (int k = 0; k < NROWS; k++) begin
         @(posedge clock); #1;
         frame_start = tbl[k].fs;
         vpfs_in     = tbl[k].vec;
         @(negedge clock);
         if (tbl[k].ev) hold = tbl[k].eadr;
         chk($sformatf("row%0d adr_valid", k),   128'(adr_valid),   128'(tbl[k].ev));
         chk($sformatf("row%0d adr_out", k),     128'(adr_out),     128'(hold));
         chk($sformatf("row%0d frame_valid", k), 128'(frame_valid), 128'(tbl[k].efv));
         if (tbl[k].efv) begin
            chk($sformatf("row%0d cluster_cnt", k),  128'(cluster_cnt),  128'(tbl[k].ecnt));
            chk($sformatf("row%0d overflow", k),     128'(overflow),     128'(tbl[k].eovf));
            chk($sformatf("row%0d clusters_out", k), 128'(clusters_out), 128'(tbl[k].eclus));
         end
      end

      // ---------------- mid-frame reset after 4 of 6 hits ----------------
      for (int k = 0; k < 7; k++) begin
         @(posedge clock); #1;
         frame_start = 1'b0;
         vpfs_in     = (k < 6) ? range_vec(100 + k, 105) : '0;
         @(negedge clock);
         if (k >= 3) begin
            chk($sformatf("midrst hit%0d valid", k - 3), 128'(adr_valid), 128'(1));
            chk($sformatf("midrst hit%0d adr", k - 3),   128'(adr_out),   128'(100 + k - 3));
         end
      end
      #2;
      global_reset_n = 1'b0;
      #1;
      check_reset("midrst async");
      @(negedge clock);
      check_reset("midrst held");
      global_reset_n = 1'b1;
      for (int j = 0; j < 10; j++) begin
         @(posedge clock); #1;
         frame_start = (j == 0 || j == 2);
         vpfs_in     = '0;
         @(negedge clock);
         chk($sformatf("post%0d adr_valid", j),   128'(adr_valid),   128'(0));
         chk($sformatf("post%0d adr_out", j),     128'(adr_out),     128'(0));
         chk($sformatf("post%0d frame_valid", j), 128'(frame_valid), 128'(j == 6));
         if (j == 6) begin
            chk("post cluster_cnt",  128'(cluster_cnt),  128'(0));
            chk("post overflow",     128'(overflow),     128'(0));
            chk("post clusters_out", 128'(clusters_out), 128'({CLW{1'b1}}));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
